// File: rtl/plot_scheduler.sv
// plot_scheduler
//
// Shares one VGA adapter write port between three region plotters (top,
// middle, bottom blitters). Redraw requests are latched into a pending set
// and served one plotter at a time in round-robin order. The granted
// plotter's writeEn is held high until it pulses done_plotting. A short
// idle gap then lets its ROM pipeline drain before the next grant.
//
// Ports
//   clk          system clock
//   resetn       asynchronous active-low reset
//   req[2:0]     one-cycle redraw request, bit i = plotter i
//   done_in[2:0] done_plotting pulses from the plotters
//   x_inN/y_inN  plotter N pixel coordinates (9 bits)
//   colour_inN   plotter N registered ROM output (6 bits)
//   en_out[2:0]  writeEn to each plotter, one-hot or zero
//   vga_x/vga_y  pixel coordinates to the VGA adapter (y truncated to 8 bits)
//   vga_colour   pixel colour to the VGA adapter
//   vga_plot     pixel write strobe
//   busy         scheduler is not idle
//   active_id    index of the current or most recently granted plotter
//   all_done     one-cycle pulse when the pending set empties after a plot

module plot_scheduler #(
  parameter int NREQ       = 3,
  parameter int GAP_CYCLES = 2
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic [2:0] req,
  input  logic [2:0] done_in,
  input  logic [8:0] x_in0,
  input  logic [8:0] x_in1,
  input  logic [8:0] x_in2,
  input  logic [8:0] y_in0,
  input  logic [8:0] y_in1,
  input  logic [8:0] y_in2,
  input  logic [5:0] colour_in0,
  input  logic [5:0] colour_in1,
  input  logic [5:0] colour_in2,
  output logic [2:0] en_out,
  output logic [8:0] vga_x,
  output logic [7:0] vga_y,
  output logic [5:0] vga_colour,
  output logic       vga_plot,
  output logic       busy,
  output logic [1:0] active_id,
  output logic       all_done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    GAP  = 2'd2
  } state_t;

  localparam logic [2:0] GAP_LAST = 3'(GAP_CYCLES - 1);

  state_t            state, state_nxt;
  logic [NREQ-1:0]   pending, pending_nxt;
  logic [1:0]        rr_ptr, rr_ptr_nxt;
  logic [1:0]        active_id_nxt;
  logic [2:0]        gap_cnt, gap_cnt_nxt;
  logic              all_done_nxt;

  logic              sel_vld;
  logic [1:0]        sel;
  logic              done_act;

  logic [8:0]        x_mux;
  logic [7:0]        y_mux;
  logic [5:0]        colour_mux;

  logic [8:0]        x_p1;
  logic [7:0]        y_p1;
  logic              vld_p1;

  // Only the low 8 bits of y reach the adapter; the MSBs are deliberately
  // dropped.
  logic              unused_y_msb;
  assign unused_y_msb = y_in0[8] ^ y_in1[8] ^ y_in2[8];

  // Modulo-3 increment of a plotter index.
  function automatic logic [1:0] wrap_inc(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  function automatic logic [2:0] onehot(input logic [1:0] id);
    logic [2:0] oh;
    oh = 3'b000;
    case (id)
      2'd0:    oh = 3'b001;
      2'd1:    oh = 3'b010;
      2'd2:    oh = 3'b100;
      default: oh = 3'b000;
    endcase
    return oh;
  endfunction

  // First set bit of pend, searching ptr, ptr+1, ptr+2 (mod 3).
  // Result is {found, index}.
  function automatic logic [2:0] rr_pick(input logic [2:0] pend,
                                         input logic [1:0] ptr);
    logic [1:0] i0, i1, i2;
    logic [2:0] r;
    i0 = ptr;
    i1 = wrap_inc(i0);
    i2 = wrap_inc(i1);
    r  = 3'b000;
    if ((pend & onehot(i0)) != 3'b000)      r = {1'b1, i0};
    else if ((pend & onehot(i1)) != 3'b000) r = {1'b1, i1};
    else if ((pend & onehot(i2)) != 3'b000) r = {1'b1, i2};
    return r;
  endfunction

  assign {sel_vld, sel} = rr_pick(pending, rr_ptr);

  // Only the granted plotter's done counts; the others are ignored.
  assign done_act = (done_in & onehot(active_id)) != 3'b000;

  always_comb begin
    x_mux      = x_in0;
    y_mux      = y_in0[7:0];
    colour_mux = colour_in0;
    case (active_id)
      2'd1: begin
        x_mux      = x_in1;
        y_mux      = y_in1[7:0];
        colour_mux = colour_in1;
      end
      2'd2: begin
        x_mux      = x_in2;
        y_mux      = y_in2[7:0];
        colour_mux = colour_in2;
      end
      default: begin
        x_mux      = x_in0;
        y_mux      = y_in0[7:0];
        colour_mux = colour_in0;
      end
    endcase
  end

  // Next-state logic. A request arriving on any cycle ORs into pending after
  // the grant clear, so a re-request during a plotter's own grant, run or
  // gap is kept and served on its next round-robin turn.
  always_comb begin
    state_nxt     = state;
    pending_nxt   = pending | req;
    rr_ptr_nxt    = rr_ptr;
    active_id_nxt = active_id;
    gap_cnt_nxt   = gap_cnt;
    all_done_nxt  = 1'b0;
    case (state)
      IDLE: begin
        if (sel_vld) begin
          state_nxt     = RUN;
          active_id_nxt = sel;
          rr_ptr_nxt    = wrap_inc(sel);
          pending_nxt   = (pending & ~onehot(sel)) | req;
        end
      end
      RUN: begin
        if (done_act) begin
          state_nxt   = GAP;
          gap_cnt_nxt = 3'd0;
        end
      end
      GAP: begin
        if (gap_cnt == GAP_LAST) begin
          state_nxt    = IDLE;
          gap_cnt_nxt  = 3'd0;
          all_done_nxt = (pending_nxt == 3'b000);
        end else begin
          gap_cnt_nxt = gap_cnt + 3'd1;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= IDLE;
      pending   <= '0;
      rr_ptr    <= 2'd0;
      active_id <= 2'd0;
      gap_cnt   <= 3'd0;
      all_done  <= 1'b0;
    end else begin
      state     <= state_nxt;
      pending   <= pending_nxt;
      rr_ptr    <= rr_ptr_nxt;
      active_id <= active_id_nxt;
      gap_cnt   <= gap_cnt_nxt;
      all_done  <= all_done_nxt;
    end
  end

  // ---- stage p0 -> p1: register the granted plotter's coordinates ----
  // The plotter's ROM colour lags its x/y by one cycle, so delaying x/y here
  // lines them up with the colour that arrives combinationally next cycle.
  // The cycle on which done is seen writes no pixel.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      x_p1   <= 9'd0;
      y_p1   <= 8'd0;
      vld_p1 <= 1'b0;
    end else begin
      x_p1   <= x_mux;
      y_p1   <= y_mux;
      vld_p1 <= (state == RUN) && !done_act;
    end
  end

  assign vga_x      = x_p1;
  assign vga_y      = y_p1;
  assign vga_plot   = vld_p1;
  // Colour is only driven while a pixel is being written so the port reads
  // zero out of reset and between plots.
  assign vga_colour = vld_p1 ? colour_mux : 6'd0;

  assign en_out = (state == RUN) ? onehot(active_id) : 3'b000;
  assign busy   = (state != IDLE);

endmodule

// File: tb/tb_plot_scheduler.sv
module tb_plot_scheduler;

  localparam int GAPC = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       resetn = 1'b0;
  logic [2:0] req = 3'b000;
  logic [2:0] done_in = 3'b000;
  logic [8:0] x_in0, x_in1, x_in2, y_in0, y_in1, y_in2;
  logic [5:0] colour_in0, colour_in1, colour_in2;
  logic [2:0] en_out;
  logic [8:0] vga_x;
  logic [7:0] vga_y;
  logic [5:0] vga_colour;
  logic       vga_plot, busy, all_done;
  logic [1:0] active_id;

  logic [8:0] xi[3];
  logic [8:0] yi[3];
  logic [5:0] ci[3];

  assign x_in0 = xi[0];
  assign x_in1 = xi[1];
  assign x_in2 = xi[2];
  assign y_in0 = yi[0];
  assign y_in1 = yi[1];
  assign y_in2 = yi[2];
  assign colour_in0 = ci[0];
  assign colour_in1 = ci[1];
  assign colour_in2 = ci[2];

  plot_scheduler #(.NREQ(3), .GAP_CYCLES(GAPC)) dut (
    .clk(clk), .resetn(resetn), .req(req), .done_in(done_in),
    .x_in0(x_in0), .x_in1(x_in1), .x_in2(x_in2),
    .y_in0(y_in0), .y_in1(y_in1), .y_in2(y_in2),
    .colour_in0(colour_in0), .colour_in1(colour_in1), .colour_in2(colour_in2),
    .en_out(en_out), .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour),
    .vga_plot(vga_plot), .busy(busy), .active_id(active_id), .all_done(all_done)
  );

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;

  // stimulus controls
  logic       rst_drv = 1'b0;
  logic [2:0] req_drv = 3'b000;
  logic [2:0] spur_drv = 3'b000;
  bit         rand_len = 0;
  bit         y_all_ones = 0;
  int         len[3] = '{3, 3, 3};
  int         run_cnt[3] = '{0, 0, 0};
  logic [8:0] xbase[3];
  logic [8:0] prev_x[3];
  logic [2:0] prev_en = 3'b000;

  int grant_q[$];
  int grant_cyc[$];
  int alld_cyc[$];

  // reference model: phase 0=idle, 1=plotting, 2=gap
  int         m_phase, m_gap_left, m_rr, m_id, m_vx, m_vy;
  logic [2:0] m_pend;
  bit         m_alld, m_plot;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  function automatic int oh2id(input logic [2:0] oh);
    if (oh == 3'b001) return 0;
    if (oh == 3'b010) return 1;
    if (oh == 3'b100) return 2;
    return 3;
  endfunction

  task automatic model_reset();
    m_phase = 0; m_gap_left = 0; m_rr = 0; m_id = 0;
    m_vx = 0; m_vy = 0; m_pend = 3'b000; m_alld = 0; m_plot = 0;
    for (int i = 0; i < 3; i++) run_cnt[i] = 0;
  endtask

  // One clock edge of the behavioural scheduler.
  task automatic model_step();
    logic [2:0] pend_after;
    int         sel;
    bit         found;
    int         nx, ny;
    bit         nplot, nalld;
    pend_after = m_pend | req;
    nx    = xi[m_id];
    ny    = yi[m_id] & 9'h0FF;
    nplot = (m_phase == 1) && done_in[m_id] == 1'b0;
    nalld = 0;
    sel   = 0;
    found = 0;
    if (m_phase == 0) begin
      for (int k = 0; k < 3; k++) begin
        if (!found && m_pend[(m_rr + k) % 3]) begin
          sel = (m_rr + k) % 3;
          found = 1;
        end
      end
      if (found) begin
        m_phase = 1;
        m_id = sel;
        m_rr = (sel + 1) % 3;
        pend_after = (m_pend & ~(3'b001 << sel)) | req;
      end
    end else if (m_phase == 1) begin
      if (done_in[m_id]) begin
        m_phase = 2;
        m_gap_left = GAPC;
      end
    end else begin
      m_gap_left--;
      if (m_gap_left == 0) begin
        m_phase = 0;
        nalld = (pend_after == 3'b000);
      end
    end
    m_pend = pend_after;
    m_vx = nx;
    m_vy = ny;
    m_plot = nplot;
    m_alld = nalld;
  endtask

  // One cycle: compare outputs of the last edge, drive the plotters and
  // requests for the next edge, then advance the model across that edge.
  task automatic tick();
    int want_en;
    @(negedge clk);
    cyc++;
    want_en = (m_phase == 1) ? (1 << m_id) : 0;
    chk("en_out", en_out, want_en);
    chk("busy", busy, (m_phase != 0) ? 1 : 0);
    chk("active_id", active_id, m_id);
    chk("all_done", all_done, m_alld);
    chk("vga_plot", vga_plot, m_plot);
    chk("vga_x", vga_x, m_vx);
    chk("vga_y", vga_y, m_vy);
    if (en_out != 3'b000 && prev_en == 3'b000) begin
      grant_q.push_back(oh2id(en_out));
      grant_cyc.push_back(cyc);
    end
    if (all_done) alld_cyc.push_back(cyc);
    prev_en = en_out;

    resetn = rst_drv;
    for (int i = 0; i < 3; i++) begin
      if (en_out[i] && resetn) begin
        run_cnt[i]++;
        if (run_cnt[i] == 1) begin
          xbase[i] = 9'($urandom);
          if (rand_len) len[i] = $urandom_range(1, 12);
        end
        xi[i] = xbase[i] + 9'(run_cnt[i] - 1);
        done_in[i] = (run_cnt[i] == len[i]);
      end else begin
        run_cnt[i] = 0;
        xi[i] = 9'($urandom);
        done_in[i] = spur_drv[i];
      end
      // registered ROM: colour is the previous cycle's address
      ci[i] = prev_x[i][5:0];
      prev_x[i] = xi[i];
      yi[i] = y_all_ones ? 9'h1FF : 9'($urandom);
    end
    req = req_drv;
    #1;
    chk("vga_colour", vga_colour, m_plot ? int'(ci[m_id]) : 0);
    if (vga_plot) chk("colour_vs_x", vga_colour, vga_x[5:0]);
    if (resetn) model_step();
    else model_reset();
  endtask

  task automatic wait_idle(input string name);
    int streak;
    streak = 0;
    for (int n = 0; n < 400 && streak < 3; n++) begin
      tick();
      if (!busy && en_out == 3'b000) streak++;
      else streak = 0;
    end
    chk({name, "_settle"}, (streak >= 3) ? 1 : 0, 1);
  endtask

  task automatic clear_logs();
    grant_q.delete();
    grant_cyc.delete();
    alld_cyc.delete();
  endtask

  task automatic do_reset();
    rst_drv = 1'b0;
    repeat (3) tick();
    rst_drv = 1'b1;
  endtask

  initial begin
    int n_run, n_plot, n_gap;
    bit seen;
    for (int i = 0; i < 3; i++) begin
      xi[i] = '0; yi[i] = '0; ci[i] = '0; prev_x[i] = '0; xbase[i] = '0;
    end
    model_reset();

    // ---------------- reset then idle ----------------
    do_reset();
    chk("rst_en", en_out, 0);
    chk("rst_vga_x", vga_x, 0);
    chk("rst_vga_y", vga_y, 0);
    chk("rst_colour", vga_colour, 0);
    chk("rst_active_id", active_id, 0);
    chk("rst_all_done", all_done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_plot", vga_plot, 0);
    repeat (20) begin
      tick();
      chk("idle_quiet", {en_out, busy, vga_plot}, 0);
    end

    // ---------------- single request, 10-cycle plot ----------------
    len[1] = 10;
    y_all_ones = 1;
    req_drv = 3'b010;
    tick();
    req_drv = 3'b000;
    tick();
    chk("grant_lat_1", en_out, 3'b000);
    tick();
    chk("grant_lat_2", en_out, 3'b010);
    n_run = 1; n_plot = 0; n_gap = 0; seen = 0;
    for (int n = 0; n < 50 && !seen; n++) begin
      tick();
      if (en_out == 3'b010) n_run++;
      if (vga_plot) begin
        n_plot++;
        chk("y_trunc", vga_y, 8'hFF);
      end
      if (busy && en_out == 3'b000) n_gap++;
      if (all_done) begin
        seen = 1;
        chk("alld_not_busy", busy, 0);
      end
    end
    chk("single_alld_seen", seen, 1);
    chk("single_run_cycles", n_run, 10);
    chk("single_plot_cycles", n_plot, 9);
    chk("single_gap_cycles", n_gap, 2);
    tick();
    chk("alld_pulse_width", all_done, 0);
    y_all_ones = 0;

    // ---------------- round-robin from reset ----------------
    do_reset();
    len = '{3, 3, 3};
    clear_logs();
    req_drv = 3'b111;
    tick();
    req_drv = 3'b000;
    wait_idle("rr3");
    chk("rr3_count", grant_q.size(), 3);
    chk("rr3_g0", (grant_q.size() > 0) ? grant_q[0] : -1, 0);
    chk("rr3_g1", (grant_q.size() > 1) ? grant_q[1] : -1, 1);
    chk("rr3_g2", (grant_q.size() > 2) ? grant_q[2] : -1, 2);
    chk("rr3_alld", alld_cyc.size(), 1);
    clear_logs();
    req_drv = 3'b011;
    tick();
    req_drv = 3'b000;
    wait_idle("rr2");
    chk("rr2_count", grant_q.size(), 2);
    chk("rr2_g0", (grant_q.size() > 0) ? grant_q[0] : -1, 0);
    chk("rr2_g1", (grant_q.size() > 1) ? grant_q[1] : -1, 1);

    // ---------------- re-request during RUN ----------------
    len[1] = 6;
    len[2] = 3;
    clear_logs();
    req_drv = 3'b010;
    tick();
    req_drv = 3'b000;
    repeat (3) tick();
    req_drv = 3'b110;
    tick();
    req_drv = 3'b000;
    wait_idle("rereq");
    chk("rereq_count", grant_q.size(), 3);
    chk("rereq_g0", (grant_q.size() > 0) ? grant_q[0] : -1, 1);
    chk("rereq_g1", (grant_q.size() > 1) ? grant_q[1] : -1, 2);
    chk("rereq_g2", (grant_q.size() > 2) ? grant_q[2] : -1, 1);
    chk("rereq_alld_n", alld_cyc.size(), 1);
    chk("rereq_alld_last",
        (alld_cyc.size() == 1 && grant_cyc.size() == 3 && alld_cyc[0] > grant_cyc[2]) ? 1 : 0, 1);

    // ---------------- spurious done from a non-granted plotter ----------------
    len[2] = 20;
    clear_logs();
    req_drv = 3'b100;
    tick();
    req_drv = 3'b000;
    repeat (4) tick();
    chk("spur_before", en_out, 3'b100);
    spur_drv = 3'b001;
    tick();
    spur_drv = 3'b000;
    tick();
    chk("spur_en_held", en_out, 3'b100);
    chk("spur_busy", busy, 1);
    wait_idle("spur");
    chk("spur_grants", grant_q.size(), 1);

    // ---------------- asynchronous reset mid-plot ----------------
    len[0] = 15;
    req_drv = 3'b001;
    tick();
    req_drv = 3'b000;
    repeat (4) tick();
    chk("midrst_running", en_out, 3'b001);
    resetn = 1'b0;
    rst_drv = 1'b0;
    #1;
    chk("midrst_en", en_out, 3'b000);
    chk("midrst_busy", busy, 0);
    chk("midrst_plot", vga_plot, 0);
    model_reset();
    repeat (2) tick();
    rst_drv = 1'b1;
    repeat (3) tick();

    // ---------------- randomized traffic ----------------
    rand_len = 1;
    for (int n = 0; n < 800; n++) begin
      for (int i = 0; i < 3; i++) begin
        req_drv[i]  = ($urandom_range(0, 9) == 0);
        spur_drv[i] = ($urandom_range(0, 5) == 0);
      end
      tick();
    end
    req_drv = 3'b000;
    spur_drv = 3'b000;
    wait_idle("random");

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/plot_scheduler.md
Name: plot_scheduler

Overview:
- Sequences three region plotters (top, middle, bottom image blitters) that share the single VGA adapter write port.
- Latches redraw requests and grants one plotter at a time in round-robin order by driving its writeEn.
- Waits for that plotter's done_plotting pulse before moving on.
- Muxes the granted plotter's x/y/colour onto the VGA port, aligning coordinates with the one-cycle ROM read latency.

Parameters:
- NREQ, 3, number of plotters. Fixed at 3; the ports below assume 3.
- GAP_CYCLES, 2, idle cycles between grants. Flushes the ROM pipeline. Range 1..7.

Ports:
- clk  in  1  system clock
- resetn  in  1  asynchronous active-low reset
- req  in  3  one-cycle redraw request per plotter; bit i = plotter i
- done_in  in  3  done_plotting pulses from plotters
- x_in0, x_in1, x_in2  in  9 each  plotter x coordinates
- y_in0, y_in1, y_in2  in  9 each  plotter y coordinates
- colour_in0, colour_in1, colour_in2  in  6 each  plotter ROM outputs
- en_out  out  3  writeEn to each plotter; one-hot or zero
- vga_x  out  9  pixel x to the VGA adapter
- vga_y  out  8  pixel y, equal to y_in[7:0]
- vga_colour  out  6  pixel colour
- vga_plot  out  1  pixel write strobe
- busy  out  1  high in any state except IDLE
- active_id  out  2  index of the current or last granted plotter
- all_done  out  1  one-cycle pulse when the pending set empties after a grant

Behaviour:
- Reset (asynchronous, resetn=0) drives these values:
  - pending=0, rr_ptr=0, state=IDLE, gap counter=0
  - en_out=0, vga_plot=0, vga_x=0, vga_y=0, vga_colour=0
  - busy=0, active_id=0, all_done=0
- Reset asserted mid-plot aborts immediately. The plotters' own resets handle their counters.
- pending[i] set rule:
  - Set on any cycle with req[i]=1.
  - Cleared on the cycle plotter i is granted (IDLE->RUN).
  - A req[i] on the grant cycle or during RUN/GAP of plotter i re-sets pending[i]. Plotter i is redrawn later and no request is lost.
  - Repeated req while pending has no further effect.
- State machine:
  - IDLE: if pending!=0, select the first set bit searching from rr_ptr upward modulo 3. Then go to RUN: en_out[sel]=1, active_id=sel, rr_ptr=(sel+1) mod 3, clear pending[sel].
  - RUN: en_out stays one-hot. When done_in[active_id]=1, drop en_out to 0 on the next edge and enter GAP.
    - done_in bits of non-granted plotters are ignored.
    - No timeout: RUN holds indefinitely until done.
  - GAP: count GAP_CYCLES cycles with en_out=0, then go to IDLE.
    - all_done pulses on the GAP->IDLE edge if pending==0 at that edge, including requests arriving that cycle.
- Grant latency: a req arriving in IDLE gives en_out high 2 cycles later. Cycle 1 latches pending; cycle 2 is the IDLE decision.
- Datapath:
  - The plotter's colour lags its x/y by one cycle (registered ROM).
  - Each cycle, register x_in/y_in of active_id, so vga_x/vga_y(t+1) = x/y(t).
  - vga_colour(t+1) = colour_in(active_id) at t+1, passed combinationally from the registered ROM output.
  - vga_plot(t+1) = (state==RUN at t) AND NOT done_in[active_id](t).
  - The cycle on which done is seen therefore writes no pixel.
- Width: vga_y truncates y_in to 8 bits. x/y arithmetic is the plotter's job; no range clamping here.
- Simultaneous events:
  - Multiple req bits in one cycle all latch.
  - done_in and req for the same plotter in one cycle: the plotter finishes, pending re-sets, and it is re-granted after the GAP only when its turn comes in round-robin order.
- Fairness: with all three pending, the grant order is rr_ptr, rr_ptr+1, rr_ptr+2. No plotter waits more than 2 other plots.

Test Plan:
- Reset then idle: resetn=0 for 3 cycles, release, no req -> en_out=0, busy=0, vga_plot=0 for 20 cycles. Assert resetn=0 mid-RUN -> en_out=0 the same cycle (async).
- Single request: req=3'b010 pulse, plotter model asserts done 10 cycles after enable -> en_out=3'b010 2 cycles after req. vga_plot is high for 9 consecutive cycles with vga_x/vga_y equal to the model's x/y delayed one cycle. en_out=0 after done, then 2 GAP cycles, then all_done pulse, then busy=0.
- Round-robin: req=3'b111 in one cycle from reset -> grants in order 0,1,2. Then req=3'b011 -> grant 0 first (rr_ptr wrapped to 0), then 1.
- Re-request during RUN: during plotter 1 RUN, pulse req[1] and req[2] -> plotter 1 finishes, then 2 is granted, then 1 again. all_done only after the second plot of plotter 1.
- Spurious done: done_in[0]=1 while plotter 2 is granted -> no state change, en_out stays 3'b100.
- Pixel alignment: model colour=address[5:0] from a 1-cycle ROM and x=address -> every vga_plot cycle shows vga_colour==vga_x[5:0]. vga_y=9'h1FF input -> vga_y=8'hFF.
